hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage core, generalising the single-cycle hazard unit to register files of any size, a third source operand (FMA), and variable-latency functional units (FPU, divider) writing back out of order. It sits beside the F/D/E/M/W pipeline registers. A scoreboard of outstanding long-latency ops drives the stall, flush and forward selects. Port collisions and cache/I/O freezes are resolved inside the block.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_scoreboard_sb_table.sv | 98 +++++++++
 rtl/hazard_scoreboard.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the hazard scoreboard.
// Contents: forward-select encoding, scoreboard entry layout, default widths.
package hazard_pkg;
    localparam int REG_AW_DEF = 6;
    localparam int LAT_W_DEF  = 4;
    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10,
        FWD_LONG = 2'b11
    } fwd_sel_e;
    typedef struct packed {
        logic                 valid;
        logic [REG_AW_DEF-1:0] rd;
        logic [LAT_W_DEF-1:0]  cnt;
    } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard_sb_table.sv
// sb_table: table of outstanding long-latency ops with countdown and match logic.
// Ports: clk/rst_n; issue_i/issue_rd_i/issue_lat_i allocate the lowest free entry;
// wb_valid_i/wb_rd_i retire the lowest matching entry (sb_err_o if none);
// rs*_i/rd_i are compared against valid entries (*_hit_o); cnt3_o flags an
// entry one W-slot ahead of a newly decoded instruction; pend_cnt_o counts valid entries.
module sb_table
    import hazard_pkg::*;
#(
    parameter  int REG_AW = REG_AW_DEF,
    parameter  int N_PEND = 4,
    parameter  int LAT_W  = LAT_W_DEF,
    localparam int CW     = $clog2(N_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_i,
    input  logic [REG_AW-1:0] issue_rd_i,
    input  logic [LAT_W-1:0]  issue_lat_i,
    input  logic              wb_valid_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rs3_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              rs1_hit_o,
    output logic              rs2_hit_o,
    output logic              rs3_hit_o,
    output logic              rd_hit_o,
    output logic              cnt3_o,
    output logic [CW-1:0]     pend_cnt_o,
    output logic              sb_err_o
);
    logic [N_PEND-1:0]             v_q, v_d;
    logic [N_PEND-1:0][REG_AW-1:0] ent_rd_q, ent_rd_d;
    logic [N_PEND-1:0][LAT_W-1:0]  cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic                          wb_hit, placed;

    always_comb begin
        v_d      = v_q;
        ent_rd_d = ent_rd_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wb_hit   = 1'b0;
        placed   = 1'b0;
        for (int i = 0; i < N_PEND; i++)
            cnt_d[i] = (cnt_q[i] == '0) ? '0 : cnt_q[i] - LAT_W'(1);
        // completion retires only the lowest-index matching entry
        for (int i = 0; i < N_PEND; i++)
            if (wb_valid_i && !wb_hit && v_q[i] && ent_rd_q[i] == wb_rd_i) begin
                v_d[i] = 1'b0;
                wb_hit = 1'b1;
            end
        if (wb_valid_i && !wb_hit)
            err_d = 1'b1;
        // allocation looks at registered occupancy, so it never reuses a slot freed this cycle
        for (int i = 0; i < N_PEND; i++)
            if (issue_i && !placed && !v_q[i]) begin
                v_d[i]      = 1'b1;
                ent_rd_d[i] = issue_rd_i;
                cnt_d[i]    = issue_lat_i;
                placed      = 1'b1;
            end
    end

    always_comb begin
        rs1_hit_o  = 1'b0;
        rs2_hit_o  = 1'b0;
        rs3_hit_o  = 1'b0;
        rd_hit_o   = 1'b0;
        cnt3_o     = 1'b0;
        pend_cnt_o = '0;
        for (int i = 0; i < N_PEND; i++)
            if (v_q[i]) begin
                rs1_hit_o  = rs1_hit_o | (ent_rd_q[i] == rs1_i);
                rs2_hit_o  = rs2_hit_o | (ent_rd_q[i] == rs2_i);
                rs3_hit_o  = rs3_hit_o | (ent_rd_q[i] == rs3_i);
                rd_hit_o   = rd_hit_o  | (ent_rd_q[i] == rd_i);
                cnt3_o     = cnt3_o    | (cnt_q[i] == LAT_W'(3));
                pend_cnt_o = pend_cnt_o + CW'(1);
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v_q      <= '0;
            ent_rd_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            v_q      <= v_d;
            ent_rd_q <= ent_rd_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end

    assign sb_err_o = err_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall/flush/forward control for the 5-stage core with long-latency units.
// Ports: D-stage sources/dest/long-op info, E-stage operands and load flag, M/W write-back
// info, long-unit completion, branch and freeze requests in; per-stage stalls, D/E flushes,
// three E-operand forward selects, pending-op count and sticky scoreboard error out.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int REG_AW = REG_AW_DEF,
    parameter  int N_PEND = 4,
    parameter  int LAT_W  = LAT_W_DEF,
    localparam int CW     = $clog2(N_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs3_d,
    input  logic              rs3_used_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              reg_write_d,
    input  logic              long_d,
    input  logic [LAT_W-1:0]  lat_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rs3_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              load_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic              long_wb_valid,
    input  logic [REG_AW-1:0] long_wb_rd,
    input  logic              pc_src_e,
    input  logic              cache_stall,
    input  logic              out_stall,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              stall_w,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [1:0]        fwd_c_e,
    output logic [CW-1:0]     pend_cnt,
    output logic              sb_err
);
    logic rs1_hit, rs2_hit, rs3_hit, rd_hit, cnt3;
    logic freeze, branch, raw, waw, full, load_use, wb_col, dstall, issue;
    logic [2:0][REG_AW-1:0] src_e;
    fwd_sel_e               fw [3];

    sb_table #(.REG_AW(REG_AW), .N_PEND(N_PEND), .LAT_W(LAT_W)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_i    (issue),
        .issue_rd_i (rd_d),
        .issue_lat_i(lat_d),
        .wb_valid_i (long_wb_valid),
        .wb_rd_i    (long_wb_rd),
        .rs1_i      (rs1_d),
        .rs2_i      (rs2_d),
        .rs3_i      (rs3_d),
        .rd_i       (rd_d),
        .rs1_hit_o  (rs1_hit),
        .rs2_hit_o  (rs2_hit),
        .rs3_hit_o  (rs3_hit),
        .rd_hit_o   (rd_hit),
        .cnt3_o     (cnt3),
        .pend_cnt_o (pend_cnt),
        .sb_err_o   (sb_err)
    );

    assign freeze   = cache_stall | out_stall;
    assign branch   = pc_src_e & ~freeze;
    assign raw      = (rs1_hit & rs1_d != '0) | (rs2_hit & rs2_d != '0)
                    | (rs3_used_d & rs3_hit & rs3_d != '0);
    assign waw      = reg_write_d & rd_hit & rd_d != '0;
    assign full     = long_d & (pend_cnt == CW'(N_PEND));
    assign load_use = load_e & rd_e != '0
                    & (rd_e == rs1_d | rd_e == rs2_d | (rs3_used_d & rd_e == rs3_d));
    // a short op decoded now reaches W exactly when an entry at count 3 completes
    assign wb_col   = reg_write_d & ~long_d & cnt3;
    assign dstall   = raw | waw | full | load_use | wb_col;
    assign issue    = long_d & ~dstall & ~branch & ~freeze;

    assign stall_f = rst_n & (freeze | (dstall & ~branch));
    assign stall_d = stall_f;
    assign stall_e = rst_n & freeze;
    assign stall_m = rst_n & freeze;
    assign stall_w = rst_n & cache_stall;
    assign flush_d = ~rst_n | branch;
    assign flush_e = ~rst_n | branch | (dstall & ~freeze);

    assign src_e = {rs3_e, rs2_e, rs1_e};
    for (genvar g = 0; g < 3; g++) begin : g_fwd
        assign fw[g] = !rst_n || src_e[g] == '0                   ? FWD_RF
                     : long_wb_valid && long_wb_rd == src_e[g]    ? FWD_LONG
                     : reg_write_m && rd_m == src_e[g]            ? FWD_M
                     : reg_write_w && rd_w == src_e[g]            ? FWD_W
                     :                                              FWD_RF;
    end
    assign fwd_a_e = fw[0];
    assign fwd_b_e = fw[1];
    assign fwd_c_e = fw[2];
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] rs1_d, rs2_d, rs3_d, rd_d, rs1_e, rs2_e, rs3_e, rd_e, rd_m, rd_w, long_wb_rd;
    logic       rs3_used_d, reg_write_d, long_d, load_e, reg_write_m, reg_write_w;
    logic       long_wb_valid, pc_src_e, cache_stall, out_stall;
    logic [3:0] lat_d;
    logic       stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, sb_err;
    logic [1:0] fwd_a_e, fwd_b_e, fwd_c_e;
    logic [2:0] pend_cnt;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs3_d(rs3_d), .rs3_used_d(rs3_used_d),
        .rd_d(rd_d), .reg_write_d(reg_write_d), .long_d(long_d), .lat_d(lat_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rs3_e(rs3_e), .rd_e(rd_e), .load_e(load_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .long_wb_valid(long_wb_valid), .long_wb_rd(long_wb_rd), .pc_src_e(pc_src_e),
        .cache_stall(cache_stall), .out_stall(out_stall),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_c_e(fwd_c_e),
        .pend_cnt(pend_cnt), .sb_err(sb_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clr();
        {rs1_d, rs2_d, rs3_d, rd_d, rs1_e, rs2_e, rs3_e, rd_e, rd_m, rd_w, long_wb_rd} = '0;
        {rs3_used_d, reg_write_d, long_d, load_e, reg_write_m, reg_write_w} = '0;
        {long_wb_valid, pc_src_e, cache_stall, out_stall} = '0;
        lat_d = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst_n = 1'b0; cache_stall = 1'b1; pc_src_e = 1'b1;
        rs1_e = 6'd3; reg_write_m = 1'b1; rd_m = 6'd3;
        #2;
        chk("rst_flush_d", flush_d, 1);
        chk("rst_flush_e", flush_e, 1);
        chk("rst_stall_f", stall_f, 0);
        chk("rst_stall_w", stall_w, 0);
        chk("rst_fwd_a", fwd_a_e, 0);
        chk("rst_pend", pend_cnt, 0);
        chk("rst_err", sb_err, 0);
        tick(); clr(); rst_n = 1'b1; #1;
        chk("rel_flush_d", flush_d, 0);
        chk("rel_flush_e", flush_e, 0);
        chk("rel_stall_f", stall_f, 0);
        // long op rd=5 lat=4 then dependent add
        tick(); clr(); long_d = 1; reg_write_d = 1; rd_d = 5; lat_d = 4; #1;
        chk("issue_stall_d", stall_d, 0);
        chk("issue_flush_e", flush_e, 0);
        tick(); clr(); reg_write_d = 1; rd_d = 6; rs1_d = 5; #1;
        chk("raw_pend", pend_cnt, 1);
        chk("raw_stall_d", stall_d, 1);
        chk("raw_stall_f", stall_f, 1);
        chk("raw_flush_e", flush_e, 1);
        chk("raw_flush_d", flush_d, 0);
        tick(); #1;
        chk("raw_stall_d2", stall_d, 1);
        tick(); long_wb_valid = 1; long_wb_rd = 5; rs1_e = 5; reg_write_m = 1; rd_m = 5; #1;
        chk("cmpl_stall_d", stall_d, 1);
        chk("cmpl_fwd_a", fwd_a_e, 3);
        tick(); long_wb_valid = 0; reg_write_m = 0; rd_m = 0; rs1_e = 0; #1;
        chk("post_stall_d", stall_d, 0);
        chk("post_pend", pend_cnt, 0);
        chk("post_err", sb_err, 0);
        // write-port collision with an entry at count 3
        tick(); clr(); long_d = 1; reg_write_d = 1; rd_d = 10; lat_d = 4; #1;
        chk("col_issue", stall_d, 0);
        tick(); clr(); reg_write_d = 1; rd_d = 11; rs1_d = 1; rs2_d = 2; #1;
        chk("col_cnt4", stall_d, 0);
        tick(); #1;
        chk("col_cnt3_stall", stall_d, 1);
        chk("col_cnt3_flush", flush_e, 1);
        tick(); long_wb_valid = 1; long_wb_rd = 10; #1;
        chk("col_cnt2", stall_d, 0);
        // fill all entries
        for (int i = 0; i < 4; i++) begin
            tick(); clr(); long_d = 1; reg_write_d = 1; rd_d = 6'(20 + i); lat_d = 15; #1;
            chk("fill_issue", stall_d, 0);
        end
        tick(); clr(); long_d = 1; reg_write_d = 1; rd_d = 24; lat_d = 15; #1;
        chk("full_pend", pend_cnt, 4);
        chk("full_stall_d", stall_d, 1);
        tick(); long_wb_valid = 1; long_wb_rd = 22; #1;
        chk("full_same_cyc", stall_d, 1);
        tick(); long_wb_valid = 0; #1;
        chk("full_freed_pend", pend_cnt, 3);
        chk("full_freed_issue", stall_d, 0);
        tick(); clr(); reg_write_d = 1; rd_d = 21; #1;
        chk("waw_pend", pend_cnt, 4);
        chk("waw_stall_d", stall_d, 1);
        rd_d = 2; rs3_d = 23; #1;
        chk("rs3_unused", stall_d, 0);
        rs3_used_d = 1; #1;
        chk("rs3_used", stall_d, 1);
        #1; rst_n = 1'b0; #1;
        chk("rst_mid_pend", pend_cnt, 0);
        // load-use
        tick(); clr(); rst_n = 1'b1;
        load_e = 1; rd_e = 7; rs1_d = 1; rs2_d = 7; reg_write_d = 1; rd_d = 8; #1;
        chk("lu_stall_d", stall_d, 1);
        chk("lu_flush_e", flush_e, 1);
        tick(); clr(); reg_write_d = 1; rd_d = 8; rs1_d = 1; rs2_d = 7;
        reg_write_m = 1; rd_m = 7; rs2_e = 7; #1;
        chk("lu_release", stall_d, 0);
        chk("lu_fwd_b", fwd_b_e, 2);
        load_e = 1; rd_e = 0; rs1_d = 0; #1;
        chk("lu_x0", stall_d, 0);
        tick(); clr(); reg_write_m = 1; rd_m = 0; rs1_e = 0; reg_write_w = 1; rd_w = 3; rs3_e = 3; #1;
        chk("fwd_x0", fwd_a_e, 0);
        chk("fwd_w_c", fwd_c_e, 1);
        // freeze during branch
        tick(); clr(); cache_stall = 1; pc_src_e = 1; #1;
        chk("fz_stall_f", stall_f, 1);
        chk("fz_stall_d", stall_d, 1);
        chk("fz_stall_e", stall_e, 1);
        chk("fz_stall_m", stall_m, 1);
        chk("fz_stall_w", stall_w, 1);
        chk("fz_flush_d", flush_d, 0);
        chk("fz_flush_e", flush_e, 0);
        tick(); cache_stall = 0; #1;
        chk("br_flush_d", flush_d, 1);
        chk("br_flush_e", flush_e, 1);
        chk("br_stall_f", stall_f, 0);
        chk("br_stall_w", stall_w, 0);
        load_e = 1; rd_e = 7; rs1_d = 7; #1;
        chk("br_ovr_stall_d", stall_d, 0);
        chk("br_ovr_flush_e", flush_e, 1);
        tick(); clr(); out_stall = 1; long_d = 1; reg_write_d = 1; rd_d = 30; lat_d = 2; #1;
        chk("out_stall_e", stall_e, 1);
        chk("out_stall_f", stall_f, 1);
        tick(); clr(); #1;
        chk("fz_noissue", pend_cnt, 0);
        // orphan completion
        tick(); long_wb_valid = 1; long_wb_rd = 9; #1;
        chk("err_before", sb_err, 0);
        tick(); clr(); #1;
        chk("err_set", sb_err, 1);
        tick(); tick(); #1;
        chk("err_sticky", sb_err, 1);
        rst_n = 1'b0; #1;
        chk("err_rst", sb_err, 0);
        tick(); rst_n = 1'b1; #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
